// File: rtl/if_id_queue_pkg.sv
// Shared pipeline definitions for the fetch/decode boundary: NOP encoding,
// exception-code width and the layout of one queued instruction entry.
package if_id_queue_pkg;

  // Instruction word used when no valid entry is presented to decode.
  localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

  // Fetch exception code width and the "no exception" encoding.
  localparam int EXC_W = 5;
  localparam logic [EXC_W-1:0] EXC_NONE = '0;

  // One queued entry: PC, instruction, fetch exception code, delay-slot flag.
  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      instr;
    logic [EXC_W-1:0] exccode;
    logic             delay;
  } entry_t;

  // Width of a packed entry (32 + 32 + 5 + 1 = 70 bits).
  localparam int ENTRY_W = $bits(entry_t);

  // Entry presented to decode while the queue is empty.
  function automatic entry_t nop_entry();
    entry_t e;
    e.pc      = 32'h0000_0000;
    e.instr   = INSTR_NOP;
    e.exccode = EXC_NONE;
    e.delay   = 1'b0;
    return e;
  endfunction

  // True when the entry carries a fetch exception.
  function automatic logic has_exception(input logic [EXC_W-1:0] code);
    return code != EXC_NONE;
  endfunction

endpackage : if_id_queue_pkg

// File: rtl/if_id_queue_mem.sv
// Entry storage for the fetch/decode queue: DEPTH x 70-bit register array
// with one synchronous write port and one asynchronous read port. The array
// is deliberately not reset; the control logic masks stale contents.
module queue_mem
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  entry_t        wr_data,
  input  logic [AW-1:0] rd_addr,
  output entry_t        rd_data
);

  entry_t mem [DEPTH];

  // Write the incoming entry at the write pointer when a push is accepted.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Head entry is read combinationally so decode sees it with no extra delay.
  assign rd_data = mem[rd_addr];

endmodule : queue_mem

// File: rtl/if_id_queue.sv
// Instruction queue between fetch and decode. Holds up to DEPTH entries in
// FIFO order. Once an entry carrying a fetch exception is accepted, further
// fetches are held off until that entry reaches decode, so nothing younger
// than a faulting instruction is ever queued behind it.
//
// Handshake: each side is a valid/ready pair. A transfer happens on a rising
// edge where both valid and ready are high. Valid never depends on ready on
// the same side; In_ready depends only on queue state and Flush, and
// Out_valid depends only on queue state.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Flush,
  input  logic                     In_valid,
  output logic                     In_ready,
  input  logic [31:0]              In_Pc,
  input  logic [31:0]              In_Instr,
  input  logic [EXC_W-1:0]         In_exccode,
  input  logic                     In_delay,
  output logic                     Out_valid,
  input  logic                     Out_ready,
  output logic [31:0]              Out_Pc,
  output logic [31:0]              Out_Instr,
  output logic [EXC_W-1:0]         Out_exccode,
  output logic                     Out_delay,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          exc_hold;

  logic          not_empty;
  logic          not_full;
  logic          push;
  logic          pop;
  entry_t        in_entry;
  entry_t        head_entry;
  entry_t        out_entry;

  // Occupancy flags and handshake qualification.
  assign not_empty = (count_q != '0);
  assign not_full  = (count_q < FULL_COUNT);
  assign In_ready  = not_full & ~exc_hold & ~Flush;
  assign push      = In_valid & In_ready;
  assign pop       = not_empty & Out_ready;

  // Pack the fetch-side fields into one storage entry.
  assign in_entry.pc      = In_Pc;
  assign in_entry.instr   = In_Instr;
  assign in_entry.exccode = In_exccode;
  assign in_entry.delay   = In_delay;

  queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (Clk),
    .wr_en   (push & Reset),
    .wr_addr (wr_ptr),
    .wr_data (in_entry),
    .rd_addr (rd_ptr),
    .rd_data (head_entry)
  );

  // Pointer, occupancy and exception-hold update; reset beats flush beats
  // push/pop. Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      exc_hold <= 1'b0;
    end else if (Flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      exc_hold <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      // The faulting entry is always the youngest queued, so its pop ends
      // the hold; a new faulting push (only possible with no hold) sets it.
      if (pop && has_exception(head_entry.exccode)) begin
        exc_hold <= 1'b0;
      end
      if (push && has_exception(In_exccode)) begin
        exc_hold <= 1'b1;
      end
    end
  end

  // Present the head entry, or a NOP with cleared fields when empty.
  assign out_entry   = not_empty ? head_entry : nop_entry();
  assign Out_valid   = not_empty;
  assign Out_Pc      = out_entry.pc;
  assign Out_Instr   = out_entry.instr;
  assign Out_exccode = out_entry.exccode;
  assign Out_delay   = out_entry.delay;
  assign Count       = count_q;

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vectors drive the fetch side and push the
// hand-computed expected entries into exp_q; a monitor pops and compares
// every entry that decode consumes.
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic [4:0]    in_exccode;
  logic          in_delay;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic [4:0]    out_exccode;
  logic          out_delay;
  logic [CW-1:0] count;

  // Expected entries as {pc, instr, exccode, delay}.
  logic [69:0] exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .Clk         (clk),
    .Reset       (rst_n),
    .Flush       (flush),
    .In_valid    (in_valid),
    .In_ready    (in_ready),
    .In_Pc       (in_pc),
    .In_Instr    (in_instr),
    .In_exccode  (in_exccode),
    .In_delay    (in_delay),
    .Out_valid   (out_valid),
    .Out_ready   (out_ready),
    .Out_Pc      (out_pc),
    .Out_Instr   (out_instr),
    .Out_exccode (out_exccode),
    .Out_delay   (out_delay),
    .Count       (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Apply one cycle of inputs; exp_acc is the hand-computed In_ready for a
  // presented entry. Returns 1 time unit after the active edge.
  task automatic drive(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] exc, input logic dly, input logic oready,
                       input logic fl, input logic rst, input logic exp_acc);
    in_valid   = iv;
    in_pc      = pc;
    in_instr   = instr;
    in_exccode = exc;
    in_delay   = dly;
    out_ready  = oready;
    flush      = fl;
    rst_n      = rst;
    if (iv && exp_acc) exp_q.push_back({pc, instr, exc, dly});
    @(negedge clk);
    if (iv) check("in_ready", {31'd0, in_ready}, {31'd0, exp_acc});
    @(posedge clk);
    #1;
    if (fl || !rst) exp_q.delete();
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [4:0] exc,
                      input logic dly, input logic oready, input logic exp_acc);
    drive(1'b1, pc, instr, exc, dly, oready, 1'b0, 1'b1, exp_acc);
  endtask

  task automatic pop_only();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Every consumed head entry must match the oldest expected entry.
  always @(negedge clk) begin
    logic [69:0] e;
    if (rst_n && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_unexpected: got pc 0x%0h expected no entry", out_pc);
      end else begin
        e = exp_q.pop_front();
        check("pop_pc",      out_pc,                  e[69:38]);
        check("pop_instr",   out_instr,               e[37:6]);
        check("pop_exccode", {27'd0, out_exccode},    {27'd0, e[5:1]});
        check("pop_delay",   {31'd0, out_delay},      {31'd0, e[0]});
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    in_valid = 0; in_pc = 0; in_instr = 0; in_exccode = 0; in_delay = 0;
    out_ready = 0; flush = 0; rst_n = 0;
    #1;
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();

    // Reset state
    check("rst_count",     32'(count),           32'd0);
    check("rst_out_valid", {31'd0, out_valid},   32'd0);
    check("rst_out_instr", out_instr,            32'h0);
    check("rst_out_pc",    out_pc,               32'h0);
    check("rst_in_ready",  {31'd0, in_ready},    32'd1);

    // Underflow: pop request while empty is ignored
    pop_only();
    check("uflow_count",     32'(count),         32'd0);
    check("uflow_out_valid", {31'd0, out_valid}, 32'd0);

    // First push visible next cycle
    push(32'h0000_3000, 32'h2408_0001, 5'd0, 1'b0, 1'b0, 1'b1);
    check("first_out_valid", {31'd0, out_valid}, 32'd1);
    check("first_out_pc",    out_pc,             32'h0000_3000);
    check("first_out_instr", out_instr,          32'h2408_0001);
    check("first_count",     32'(count),         32'd1);
    pop_only();
    check("first_drain_count", 32'(count), 32'd0);

    // Three back-to-back pushes into a depth-2 queue; third is refused
    push(32'h0000_1000, 32'h0000_0011, 5'd0, 1'b0, 1'b0, 1'b1);
    push(32'h0000_1004, 32'h0000_0022, 5'd0, 1'b1, 1'b0, 1'b1);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    push(32'h0000_1008, 32'h0000_0033, 5'd0, 1'b0, 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd2);
    pop_only();
    check("full_pop1_count", 32'(count), 32'd1);
    pop_only();
    check("full_pop2_count", 32'(count), 32'd0);

    // Simultaneous push/pop at Count=1 across pointer wrap
    push(32'h0000_4000, 32'h0000_0100, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      push(32'h0000_4000 + 32'(4 * k), 32'h0000_0100 + 32'(k), 5'd0, k[0], 1'b1, 1'b1);
      check("pp_count",  32'(count), 32'd1);
      check("pp_out_pc", out_pc,     32'h0000_4000 + 32'(4 * k));
    end
    pop_only();
    check("pp_drain_count", 32'(count), 32'd0);

    // Exception entry holds off fetch until it pops
    push(32'h0000_5000, 32'h0000_0bad, 5'd4, 1'b0, 1'b0, 1'b1);
    check("exc_out_exccode", {27'd0, out_exccode}, 32'd4);
    push(32'h0000_5004, 32'h0000_0055, 5'd0, 1'b0, 1'b0, 1'b0);
    push(32'h0000_5004, 32'h0000_0055, 5'd0, 1'b0, 1'b0, 1'b0);
    push(32'h0000_5004, 32'h0000_0055, 5'd0, 1'b0, 1'b1, 1'b0);
    check("exc_release_in_ready", {31'd0, in_ready}, 32'd1);
    push(32'h0000_5004, 32'h0000_0055, 5'd0, 1'b0, 1'b0, 1'b1);
    pop_only();
    check("exc_drain_count", 32'(count), 32'd0);

    // Flush with a concurrent push and pop request
    push(32'h0000_6000, 32'h0000_0061, 5'd0, 1'b0, 1'b0, 1'b1);
    push(32'h0000_6004, 32'h0000_0062, 5'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 32'h0000_6008, 32'h0000_0063, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("flush_count",     32'(count),         32'd0);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_out_instr", out_instr,          32'h0);
    idle();
    check("flush_in_ready",  {31'd0, in_ready},  32'd1);

    // Reset mid-operation with Count=2
    push(32'h0000_7000, 32'h0000_0071, 5'd0, 1'b1, 1'b0, 1'b1);
    push(32'h0000_7004, 32'h0000_0072, 5'd0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mrst_count",       32'(count),           32'd0);
    check("mrst_out_valid",   {31'd0, out_valid},   32'd0);
    check("mrst_out_pc",      out_pc,               32'h0);
    check("mrst_out_instr",   out_instr,            32'h0);
    check("mrst_out_exccode", {27'd0, out_exccode}, 32'd0);
    check("mrst_out_delay",   {31'd0, out_delay},   32'd0);

    // Reset clears a pending exception hold
    idle();
    push(32'h0000_8000, 32'h0000_0081, 5'd3, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    check("rst_hold_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_hold_count",    32'(count),        32'd0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_if_id_queue

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of instruction entries (power of two, >=2).
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 SHALL have port Flush  input  1  discard all queued entries (branch/exception redirect).
REQ-005 SHALL have port In_valid  input  1  fetch stage presents an entry.
REQ-006 SHALL have port In_ready  output  1  queue accepts the entry this cycle.
REQ-007 SHALL have ports In_Pc  input  32, In_Instr  input  32, In_exccode  input  5, In_delay  input  1  fetched PC, instruction, fetch exception code, delay-slot flag.
REQ-008 SHALL have port Out_valid  output  1  head entry valid for decode.
REQ-009 SHALL have port Out_ready  input  1  decode consumes head this cycle.
REQ-010 SHALL have ports Out_Pc  output  32, Out_Instr  output  32, Out_exccode  output  5, Out_delay  output  1  head entry fields.
REQ-011 SHALL have port Count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-012 SHALL store entries {Pc, Instr, exccode, delay} in FIFO order; push = In_valid & In_ready; pop = Out_valid & Out_ready.
REQ-013 SHALL drive Out_valid = (Count != 0), combinationally from state.
REQ-014 SHALL drive Out_* from the head entry, zero extra latency; when Count==0, Out_Instr=32'h0 (NOP), Out_exccode=0, Out_delay=0, Out_Pc=0.
REQ-015 SHALL drive In_ready = (Count < DEPTH) & ~exc_hold & ~Flush; no same-cycle pass-through when full.
REQ-016 SHALL set exc_hold when an entry with In_exccode != 0 is pushed; clear it when that entry pops or on Flush.
REQ-017 SHALL make an entry pushed in cycle N visible at the outputs in cycle N+1 (one-cycle latency).
REQ-018 SHALL, on simultaneous push and pop, keep Count unchanged and advance both pointers.
REQ-019 SHALL wrap read/write pointers modulo DEPTH.
REQ-020 SHALL, on Flush, set Count=0, both pointers=0, exc_hold=0 at next edge; a concurrent push or pop SHALL be ignored.
REQ-021 SHALL ignore Out_ready when Count==0 (no underflow) and never push when Count==DEPTH (no overflow).

Reset
REQ-022 SHALL, when Reset==0 at a rising edge, set Count=0, pointers=0, exc_hold=0; Out_valid=0, Out_Instr=32'h0, Out_exccode=0, Out_delay=0, Out_Pc=0 from the following cycle.
REQ-023 SHALL give Reset priority over Flush, push and pop; reset mid-operation discards all entries.
REQ-024 SHALL NOT require storage arrays to be cleared on reset; outputs are masked by Count.

Structure
REQ-025 SHALL take the NOP encoding (32'h0), exccode width (5) and EXC_NONE (0) from the shared pipeline defines header.
REQ-026 SHALL implement entry storage as one sub-module, queue_mem (DEPTH x 70-bit register array, one write port, one asynchronous read port).
REQ-027 SHALL keep pointers, Count, exc_hold and control in if_id_queue.

Verification
REQ-028 SHALL verify: reset, then push Pc=0x3000,Instr=0x24080001 -> next cycle Out_valid=1, Out_Pc=0x3000, Count=1.
REQ-029 SHALL verify: three back-to-back pushes, Out_ready=0 -> Count=2, In_ready=0 after second, third not stored; pops return order 1,2.
REQ-030 SHALL verify: Count=1, push and pop same cycle -> Count stays 1, Out_Pc becomes the new PC; 10 such cycles exercise pointer wrap.
REQ-031 SHALL verify: push In_exccode=4 -> In_ready=0 until that entry pops with Out_exccode=4, then In_ready=1.
REQ-032 SHALL verify: Count=2, Flush=1 with In_valid=1 -> next cycle Count=0, Out_valid=0, Out_Instr=0x00000000.
REQ-033 SHALL verify: Reset=0 while Count=2 and Flush=0 -> next cycle Count=0, all outputs at reset values.
